keypad_scan_ctrl: RTL

- Sequences the 4x4 keypad: drives the column strobes, samples the rows after a settle delay, and debounces each of the 16 keys.
- Turns debounced press and release edges into events, queued in a small FIFO.
- The game logic reads events over a valid/ready handshake and also sees a live bitmap of which keys are held.
- Sits between the keypad pins and the DDR step-judging logic.

---
 rtl/keypad_scan_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   4x4 keypad scanner for the step-judging front end. A column timer strobes
//   one column at a time (active-low, one-cold). After a settle delay the rows
//   are latched and the four keys of that column are debounced one per cycle.
//   Each debounced press or release becomes an event in a small show-ahead FIFO.
//
// Ports
//   CLK          system clock
//   RST          synchronous active-high reset
//   row[3:0]     keypad rows, active-low, row[3] = top row
//   col[3:0]     column strobe, active-low one-cold
//   evt_valid    FIFO head holds an event
//   evt_ready    consumer accepts the head event
//   evt_key      key code of the head event
//   evt_release  0 = press, 1 = release
//   key_state    debounced held bitmap, bit n = key code n
//   overflow     sticky: an event was dropped because the FIFO was full
//   ovf_clr      clears overflow (a same-cycle set wins)
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for timer == SETTLE in the column slot
// S_SAMPLE | latch inverted rows into r_row_q
// S_EVAL0  | debounce row 0 (top, r_row_q[3]) of the column
// S_EVAL1  | debounce row 1 (r_row_q[2])
// S_EVAL2  | debounce row 2 (r_row_q[1])
// S_EVAL3  | debounce row 3 (bottom, r_row_q[0]), back to idle

module keypad_scan_ctrl #(
  parameter int SCAN_TICKS = 100000,
  parameter int SETTLE     = 10,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_release,
  output logic [15:0] key_state,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE);
  localparam logic [2:0]    DB_LIM   = 3'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_col_idx;
  logic [3:0]      r_col;
  logic [3:0]      r_row_q;
  logic [15:0]     r_key_state;
  logic [2:0]      r_cnt [16];

  logic [4:0]      r_mem [FIFO_DEPTH];
  logic [PW:0]     r_wr_ptr;
  logic [PW:0]     r_rd_ptr;
  logic            r_overflow;

  logic            w_is_eval;
  logic [1:0]      w_row_i;
  logic [3:0]      w_key;
  logic            w_raw;
  logic [2:0]      w_cnt_inc;
  logic            w_flip;
  logic [4:0]      w_push_data;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;

  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h4;  4'b00_10: k = 4'h7;  4'b00_11: k = 4'h0;
      4'b01_00: k = 4'h2;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h8;  4'b01_11: k = 4'hF;
      4'b10_00: k = 4'h3;  4'b10_01: k = 4'h6;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hE;
      4'b11_00: k = 4'hA;  4'b11_01: k = 4'hB;  4'b11_10: k = 4'hC;  default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Column timer; the strobe rotates in the same edge that advances col_idx.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_timer   <= '0;
      r_col_idx <= 2'd0;
      r_col     <= 4'b0111;
    end else if (r_timer == T_LAST) begin
      r_timer   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col     <= {r_col[0], r_col[3:1]};
    end else begin
      r_timer   <= r_timer + TW'(1);
    end
  end

  always_comb begin
    w_is_eval = 1'b0;
    w_row_i   = 2'd0;
    case (r_state)
      S_EVAL0: begin w_is_eval = 1'b1; w_row_i = 2'd0; end
      S_EVAL1: begin w_is_eval = 1'b1; w_row_i = 2'd1; end
      S_EVAL2: begin w_is_eval = 1'b1; w_row_i = 2'd2; end
      S_EVAL3: begin w_is_eval = 1'b1; w_row_i = 2'd3; end
      default: begin w_is_eval = 1'b0; w_row_i = 2'd0; end
    endcase
    w_key       = key_code(r_col_idx, w_row_i);
    w_raw       = r_row_q[2'd3 - w_row_i];
    w_cnt_inc   = r_cnt[w_key] + 3'd1;
    w_flip      = w_is_eval && (w_raw != r_key_state[w_key]) && (w_cnt_inc == DB_LIM);
    // release flag is the state before the flip
    w_push_data = {r_key_state[w_key], w_key};
  end

  // Scan FSM and per-key debounce.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_row_q     <= 4'd0;
      r_key_state <= 16'd0;
      for (int i = 0; i < 16; i++) r_cnt[i] <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE:   if (r_timer == T_SETTLE) r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_row_q <= ~row;
          r_state <= S_EVAL0;
        end
        S_EVAL0:  r_state <= S_EVAL1;
        S_EVAL1:  r_state <= S_EVAL2;
        S_EVAL2:  r_state <= S_EVAL3;
        S_EVAL3:  r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase

      if (w_is_eval) begin
        if (w_raw == r_key_state[w_key]) begin
          r_cnt[w_key] <= 3'd0;
        end else if (w_flip) begin
          r_cnt[w_key]       <= 3'd0;
          r_key_state[w_key] <= ~r_key_state[w_key];
        end else begin
          r_cnt[w_key] <= w_cnt_inc;
        end
      end
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop     = !w_empty && evt_ready;
  // when full, a same-cycle pop frees the slot being written
  assign w_push_ok = w_flip && (!w_full || w_pop);

  // Event FIFO and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 5'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[PW-1:0]] <= w_push_data;
        r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
      if (w_flip && w_full && !w_pop) r_overflow <= 1'b1;
      else if (ovf_clr)               r_overflow <= 1'b0;
    end
  end

  assign col                    = r_col;
  assign key_state              = r_key_state;
  assign overflow               = r_overflow;
  assign evt_valid              = !w_empty;
  assign {evt_release, evt_key} = r_mem[r_rd_ptr[PW-1:0]];

endmodule
